// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch: owns the PC, reads combinational imem, holds one fetched word for decode.
// Latency: 1 cycle from PC to out_instr; 1 instruction per cycle while out_ready is high.
// Backpressure: out_ready low stalls the PC and the output entry; a redirect always flushes the entry.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    state_t      state;
    logic [31:0] pc;
    fetch_t      out_entry;
    logic        accept;
    logic        load;
    logic        pc_in_range;
    logic        redirect_bad;

    assign accept       = out_valid & out_ready;
    assign load         = (state == RUN) & (~out_valid | out_ready);
    assign pc_in_range  = pc < MEM_LIMIT;
    assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= MEM_LIMIT);

    assign imem_addr = pc;
    assign out_instr = out_entry.instr;
    assign out_pc    = out_entry.pc;
    assign fault     = (state == FAULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_entry   <= '0;
            fault_pc    <= '0;
            fetch_count <= '0;
        end else begin
            // An accept in the same cycle as a redirect is a flushed word, not a delivery.
            if (accept && !redirect_valid) begin
                fetch_count <= fetch_count + 32'd1;
            end

            if (redirect_valid) begin
                out_valid <= 1'b0;
                if (redirect_bad) begin
                    state    <= FAULT;
                    fault_pc <= redirect_pc;
                end else begin
                    state <= RUN;
                    pc    <= redirect_pc;
                end
            end else if (load) begin
                if (pc_in_range) begin
                    out_entry.instr <= imem_data;
                    out_entry.pc    <= pc;
                    out_valid       <= 1'b1;
                    pc              <= pc + 32'd4;
                end else begin
                    // Running off the end of memory: the held word (if accepted now) still counts.
                    state     <= FAULT;
                    fault_pc  <= pc;
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboarded bench for imem_fetch_ctrl with a 3-word instruction memory.
module tb_imem_fetch_ctrl;

    localparam int unsigned MSIZE = 12;
    localparam logic [31:0] W0 = 32'h2011_0001;
    localparam logic [31:0] W1 = 32'h2012_000A;
    localparam logic [31:0] W2 = 32'h0232_9820;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_count = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.RESET_PC(32'h0), .MEM_SIZE(MSIZE)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fault         (fault),
        .fault_pc      (fault_pc),
        .fetch_count   (fetch_count)
    );

    always_comb begin
        case (imem_addr)
            32'd0:   imem_data = W0;
            32'd4:   imem_data = W1;
            32'd8:   imem_data = W2;
            default: imem_data = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    // Handshakes that will complete at the next rising edge are scored here.
    always @(negedge clk) begin
        if (reset) begin
            exp_count = 0;
        end else if (out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_pc, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e[63:32]);
                chk("sb_instr", out_instr, e[31:0]);
            end
            exp_count = exp_count + 1;
        end
    end

    initial begin
        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_fpc", fault_pc, 32'd0);

        // Straight-line run into the end of memory.
        reset     = 1'b0;
        out_ready = 1'b1;
        push(32'd0, W0);
        push(32'd4, W1);
        push(32'd8, W2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("run_valid", {31'b0, out_valid}, 32'd1);
            chk("run_pc", out_pc, 32'(i * 4));
        end
        tick();
        chk("range_fault", {31'b0, fault}, 32'd1);
        chk("range_fpc", fault_pc, 32'd12);
        chk("range_valid", {31'b0, out_valid}, 32'd0);
        chk("range_count", fetch_count, 32'd3);
        chk("range_q", 32'(exp_q.size()), 32'd0);

        // Backpressure with out_pc=4 held.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        tick();
        chk("recov_fault", {31'b0, fault}, 32'd0);
        chk("recov_addr", imem_addr, 32'd0);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        push(32'd0, W0);
        push(32'd4, W1);
        tick();
        chk("bp_pc0", out_pc, 32'd0);
        tick();
        chk("bp_pc4", out_pc, 32'd4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", out_instr, W1);
            chk("stall_pc", out_pc, 32'd4);
            chk("stall_addr", imem_addr, 32'd8);
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("resume_pc", out_pc, 32'd8);
        chk("resume_instr", out_instr, W2);

        // Redirect coincident with an accept of pc 8: flushed, not counted.
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        push(32'd0, W0);
        tick();
        redirect_valid = 1'b0;
        chk("redir_bubble", {31'b0, out_valid}, 32'd0);
        chk("redir_count", fetch_count, exp_count);
        tick();
        chk("redir_valid", {31'b0, out_valid}, 32'd1);
        chk("redir_pc", out_pc, 32'd0);
        chk("redir_instr", out_instr, W0);
        tick();
        chk("pre_mis_pc", out_pc, 32'd4);

        // Misaligned redirect, then recovery.
        redirect_valid = 1'b1;
        redirect_pc    = 32'd6;
        tick();
        redirect_valid = 1'b0;
        chk("mis_fault", {31'b0, fault}, 32'd1);
        chk("mis_fpc", fault_pc, 32'd6);
        chk("mis_valid", {31'b0, out_valid}, 32'd0);
        tick();
        tick();
        chk("mis_sticky", {31'b0, fault}, 32'd1);
        chk("mis_fpc_hold", fault_pc, 32'd6);
        chk("mis_idle", {31'b0, out_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd4;
        push(32'd4, W1);
        tick();
        redirect_valid = 1'b0;
        chk("fix_fault", {31'b0, fault}, 32'd0);
        chk("fix_bubble", {31'b0, out_valid}, 32'd0);
        tick();
        chk("fix_valid", {31'b0, out_valid}, 32'd1);
        chk("fix_pc", out_pc, 32'd4);
        chk("fix_instr", out_instr, W1);
        tick();

        // Reset while out_pc=4 is valid.
        redirect_valid = 1'b1;
        redirect_pc    = 32'd4;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("prerst_pc", out_pc, 32'd4);
        chk("prerst_count", fetch_count, exp_count);
        reset = 1'b1;
        tick();
        chk("mrst_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_fault", {31'b0, fault}, 32'd0);
        chk("mrst_count", fetch_count, 32'd0);
        reset = 1'b0;
        push(32'd0, W0);
        push(32'd4, W1);
        tick();
        chk("post_valid", {31'b0, out_valid}, 32'd1);
        chk("post_pc", out_pc, 32'd0);
        tick();
        chk("post_pc4", out_pc, 32'd4);
        tick();
        out_ready = 1'b0;
        chk("end_q", 32'(exp_q.size()), 32'd0);
        chk("end_count", fetch_count, exp_count);
        chk("end_count_abs", fetch_count, 32'd2);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch controller that sequences the combinational, byte-addressed instruction memory. It owns the program counter, drives the memory address, and registers each fetched word with its PC into a one-entry output stage under a valid/ready handshake to decode. It also accepts branch/jump redirects with flush, and enters a sticky fault state on out-of-range or misaligned fetch addresses. It sits between the instruction memory and the decode stage of the MIPS core.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; word-aligned.
- MEM_SIZE, 256: instruction memory depth in byte addresses; legal fetch PCs are 0 .. MEM_SIZE-4.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- imem_addr  out  32  address to instruction memory; equals the internal pc register.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target PC for redirect.
- out_valid  out  1  out_instr/out_pc hold a valid fetched instruction.
- out_ready  in  1  decode accepts the output this cycle.
- out_instr  out  32  fetched instruction.
- out_pc  out  32  PC of out_instr.
- fault  out  1  controller is in FAULT.
- fault_pc  out  32  offending address that caused FAULT.
- fetch_count  out  32  number of completed output handshakes (out_valid & out_ready).

## Operation
- States: RUN, FAULT. Reset gives RUN.
- Reset values: pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0, fetch_count=0.
- Define accept = out_valid & out_ready and load = (state==RUN) & (!out_valid | out_ready).
- Priority at each edge: reset > redirect > load > drain.
- Redirect (any state): out_valid<=0 (the held instruction is flushed and not counted, even if out_ready=1). Then:
  - if redirect_pc[1:0]!=0 or redirect_pc>=MEM_SIZE: go to FAULT and set fault_pc<=redirect_pc;
  - otherwise: pc<=redirect_pc and go to (or stay in) RUN.
- Load in RUN with pc<MEM_SIZE: out_instr<=imem_data, out_pc<=pc, out_valid<=1, pc<=pc+4.
- Load in RUN with pc>=MEM_SIZE: go to FAULT, fault_pc<=pc, out_valid<=0, pc unchanged.
- Drain: when there is no load and accept=1, out_valid<=0. This covers FAULT with a pending output; the pending instruction is still delivered.
- Stall: while out_valid=1 and out_ready=0, out_instr, out_pc and pc hold.
- fault is 1 exactly while in FAULT.
- Leaving FAULT requires a legal redirect or reset; fault_pc holds its value until then.
- fetch_count increments by 1 on every accept that is not coincident with a redirect, and wraps modulo 2^32.
- pc+4 arithmetic is 32-bit modulo. Overflow is unreachable without first faulting on range.

## Timing
- Memory read is combinational. Fetch latency is 1 cycle: the word at pc appears on out_instr at the edge where load=1.
- Throughput is 1 instruction/cycle while out_ready=1.
- Redirect penalty: redirect sampled at edge E gives out_valid=0 after E, and the first target instruction becomes valid after E+1.
- Reset asserted mid-stream: all outputs take reset values at that edge. The first instruction (at RESET_PC) becomes valid one edge after reset deasserts.
- Range fault: out_valid falls no later than the edge after the last legal word is accepted. fault rises at the same edge the FAULT transition is taken.
- Redirect and accept in the same cycle: the redirect wins, the instruction is dropped, and fetch_count is unchanged.

## Test plan
- Memory preloaded with words 0x20110001 @0, 0x2012000A @4 and 0x02329820 @8; MEM_SIZE=12; reset for 2 cycles, then out_ready=1 held.
  - Required: out_pc/out_instr sequence 0/0x20110001, 4/0x2012000A, 8/0x02329820 on consecutive cycles.
  - Then fault=1 with fault_pc=12 and fetch_count=3.
- Backpressure: out_ready=0 for 3 cycles while out_pc=4 is held.
  - Required: out_instr stays 0x2012000A and imem_addr stays 8. After out_ready=1, 8 follows on the next cycle with no skip or duplicate.
- Redirect: assert redirect_pc=0 at the cycle out_pc=8 is valid with out_ready=1.
  - Required: pc 8 is flushed and not counted, out_valid=0 for one cycle, then out_pc=0 with 0x20110001.
- Misaligned redirect_pc=6.
  - Required: fault=1, fault_pc=6, out_valid=0. A subsequent redirect_pc=4 returns to RUN and delivers 0x2012000A after one bubble.
- Reset mid-operation: assert reset while out_pc=4 is valid.
  - Required: next cycle out_valid=0, fault=0 and fetch_count=0. After release, out_pc=0 appears one cycle later.
